// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared integer-core constants and the writeback request record used by the
// register-file write arbiter and its B-side FIFO.
//   XLEN      : integer data width
//   REG_AW    : register address width
//   wb_req_t  : one register-file write (destination + data)
//   rd_onehot : decode a register number into a 32-bit one-hot mask
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    // x0 is hardwired, so it never contributes a pending bit.
    function automatic logic [31:0] rd_onehot(input logic [REG_AW-1:0] rd);
        logic [31:0] mask;
        if (rd == '0) begin
            mask = 32'd0;
        end else begin
            mask = 32'd1 << rd;
        end
        return mask;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
// DEPTH-entry synchronous FIFO of wb_req_t. Push is ignored when full and pop
// is ignored when empty. Every slot and its valid flag are exported so the
// owner can build a hazard mask over all queued entries.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (empties the FIFO)
//   i_push       : enqueue i_push_data this cycle
//   i_push_data  : entry to enqueue
//   i_pop        : dequeue the head this cycle
//   o_head       : entry at the read pointer
//   o_count      : registered occupancy 0..DEPTH
//   o_entries    : raw storage slots
//   o_valid      : per-slot occupied flag
// ----------------------------------------------------------------------------
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  wb_req_t                i_push_data,
    input  logic                   i_pop,
    output wb_req_t                o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output wb_req_t                o_entries [DEPTH],
    output logic [DEPTH-1:0]       o_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_req_t          r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] r_valid;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & (r_count < CW'(DEPTH));
    assign w_pop  = i_pop & (r_count != '0);

    // Storage slots: data only, validity is tracked separately so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // Pointers, occupancy and per-slot valid flags. Push and pop never hit the
    // same slot because push needs not-full and pop needs not-empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_entries = r_mem;
    assign o_valid   = r_valid;

endmodule

// File: rtl/regs_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regs_wb_arbiter
// Sole driver of the integer register-file write port. Merges the in-order
// pipeline writeback (A) with queued long-latency results (B). A normally wins;
// once the FIFO head has been denied STARVE_MAX consecutive cycles it is forced
// onto the port and A is stalled for that cycle.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   a_valid/a_rd/a_data       : pipeline result; a_ready=0 means hold a_*
//   b_valid/b_rd/b_data       : long-latency result; transfer on b_valid & b_ready
//   w_regs_en/addr/data       : register-file write port (combinational)
//   pending_mask              : bit r set while a queued B entry targets xr
//   fifo_count                : B FIFO occupancy
// ----------------------------------------------------------------------------
module regs_wb_arbiter
    import riscv_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_valid,
    input  logic [REG_AW-1:0]      a_rd,
    input  logic [XLEN-1:0]        a_data,
    output logic                   a_ready,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic [REG_AW-1:0]      b_rd,
    input  logic [XLEN-1:0]        b_data,
    output logic                   w_regs_en,
    output logic [REG_AW-1:0]      w_regs_addr,
    output logic [XLEN-1:0]        w_regs_data,
    output logic [31:0]            pending_mask,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    wb_req_t          w_head;
    wb_req_t          w_entries [DEPTH];
    logic [DEPTH-1:0] w_valid;
    logic [CW-1:0]    w_count;
    logic             w_empty;
    logic             w_force_b;
    logic             w_sel_a;
    logic             w_sel_b;
    logic             w_push;
    wb_req_t          w_push_data;
    logic [SW-1:0]    r_starve;
    logic             w_en;
    logic [REG_AW-1:0] w_addr;
    logic [XLEN-1:0]  w_data;
    logic [31:0]      w_mask;

    assign w_empty          = (w_count == '0);
    assign w_force_b        = ~w_empty & (r_starve == SW'(STARVE_MAX));
    // Full-ness uses the registered count: a same-cycle pop does not free a slot early.
    assign b_ready          = (w_count < CW'(DEPTH));
    assign w_push           = b_valid & b_ready;
    assign w_push_data.rd   = b_rd;
    assign w_push_data.data = b_data;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_sel_b),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_entries   (w_entries),
        .o_valid     (w_valid)
    );

    // Source select: forced drain, then A, then an idle-port drain of the FIFO.
    always_comb begin
        w_sel_a = 1'b0;
        w_sel_b = 1'b0;
        if (w_force_b) begin
            w_sel_b = 1'b1;
        end else if (a_valid) begin
            w_sel_a = 1'b1;
        end else if (!w_empty) begin
            w_sel_b = 1'b1;
        end else begin
            w_sel_a = 1'b0;
            w_sel_b = 1'b0;
        end
    end

    // Write-port mux; an x0 target is consumed but never written.
    always_comb begin
        w_en   = 1'b0;
        w_addr = '0;
        w_data = '0;
        if (w_sel_b) begin
            w_en   = (w_head.rd != '0);
            w_addr = w_head.rd;
            w_data = w_head.data;
        end else if (w_sel_a) begin
            w_en   = (a_rd != '0);
            w_addr = a_rd;
            w_data = a_data;
        end else begin
            w_en   = 1'b0;
            w_addr = '0;
            w_data = '0;
        end
    end

    // Count consecutive cycles the queued head loses the port; saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_empty || w_sel_b) begin
            r_starve <= '0;
        end else if (r_starve != SW'(STARVE_MAX)) begin
            r_starve <= r_starve + SW'(1);
        end else begin
            r_starve <= r_starve;
        end
    end

    // OR of the destinations of every occupied FIFO slot.
    always_comb begin
        w_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i]) begin
                w_mask = w_mask | rd_onehot(w_entries[i].rd);
            end else begin
                w_mask = w_mask;
            end
        end
    end

    assign a_ready      = ~w_force_b;
    assign w_regs_en    = w_en;
    assign w_regs_addr  = w_addr;
    assign w_regs_data  = w_data;
    assign pending_mask = w_mask;
    assign fifo_count   = w_count;

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regs_wb_arbiter
// Directed stimulus for the register-file write arbiter. A queue-based model
// of the B FIFO and starvation rule predicts every output each cycle; the
// directed sequences also carry hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_regs_wb_arbiter;

    localparam int STARVE = 4;
    localparam int DEPTH  = 2;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        w_regs_en;
    logic [4:0]  w_regs_addr;
    logic [31:0] w_regs_data;
    logic [31:0] pending_mask;
    logic [1:0]  fifo_count;

    int n_vec = 0;
    int n_err = 0;

    regs_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid),
        .a_rd         (a_rd),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_rd         (b_rd),
        .b_data       (b_data),
        .w_regs_en    (w_regs_en),
        .w_regs_addr  (w_regs_addr),
        .w_regs_data  (w_regs_data),
        .pending_mask (pending_mask),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: FIFO as a queue, starvation as a plain integer.
    ent_t q[$];
    int   starve = 0;

    initial begin
        bit   live;
        bit   m_pop;
        bit   m_push;
        ent_t pe;
        forever begin
            @(negedge clk);
            live = 1'b0;
            if (!rst) begin
                int          n;
                bit          force_b;
                bit          sel_a;
                logic [4:0]  e_rd;
                logic [31:0] e_data;
                logic [31:0] e_mask;
                live    = 1'b1;
                n       = q.size();
                force_b = (n > 0) && (starve == STARVE);
                m_pop   = force_b || (!a_valid && n > 0);
                sel_a   = !force_b && a_valid;
                e_rd    = 5'd0;
                e_data  = 32'd0;
                if (m_pop) begin
                    e_rd   = q[0].rd;
                    e_data = q[0].data;
                end else if (sel_a) begin
                    e_rd   = a_rd;
                    e_data = a_data;
                end
                e_mask = 32'd0;
                foreach (q[i]) if (q[i].rd != 5'd0) e_mask[q[i].rd] = 1'b1;
                chk("m_en", {31'd0, w_regs_en}, {31'd0, (m_pop || sel_a) && (e_rd != 5'd0)});
                if ((m_pop || sel_a) && e_rd != 5'd0) begin
                    chk("m_addr", {27'd0, w_regs_addr}, {27'd0, e_rd});
                    chk("m_data", w_regs_data, e_data);
                end
                chk("m_a_ready", {31'd0, a_ready}, {31'd0, !force_b});
                chk("m_b_ready", {31'd0, b_ready}, {31'd0, n < DEPTH});
                chk("m_count", {30'd0, fifo_count}, n);
                chk("m_mask", pending_mask, e_mask);
                m_push  = b_valid && (n < DEPTH);
                pe.rd   = b_rd;
                pe.data = b_data;
            end
            @(posedge clk);
            if (rst) begin
                q.delete();
                starve = 0;
            end else if (live) begin
                if (m_pop || q.size() == 0) starve = 0;
                else if (starve < STARVE) starve++;
                if (m_pop) void'(q.pop_front());
                if (m_push) q.push_back(pe);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; a_valid = 1'b0; a_rd = 5'd0; a_data = 32'd0;
        b_valid = 1'b0; b_rd = 5'd0; b_data = 32'd0;
        step(); step();
        chk("rst_en", {31'd0, w_regs_en}, 32'd0);
        chk("rst_addr", {27'd0, w_regs_addr}, 32'd0);
        chk("rst_data", w_regs_data, 32'd0);
        chk("rst_mask", pending_mask, 32'd0);
        chk("rst_count", {30'd0, fifo_count}, 32'd0);
        chk("rst_a_ready", {31'd0, a_ready}, 32'd1);
        chk("rst_b_ready", {31'd0, b_ready}, 32'd1);
        rst = 1'b0;

        // A only
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEAD_BEEF;
        #1;
        chk("a_en", {31'd0, w_regs_en}, 32'd1);
        chk("a_addr", {27'd0, w_regs_addr}, 32'd5);
        chk("a_data", w_regs_data, 32'hDEAD_BEEF);
        chk("a_ready", {31'd0, a_ready}, 32'd1);
        step();

        // B only: no bypass, write one cycle later
        a_valid = 1'b0; b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h0000_1234;
        #1;
        chk("b_nobypass", {31'd0, w_regs_en}, 32'd0);
        step();
        b_valid = 1'b0;
        #1;
        chk("b_mask7", {31'd0, pending_mask[7]}, 32'd1);
        chk("b_addr", {27'd0, w_regs_addr}, 32'd7);
        chk("b_data", w_regs_data, 32'h0000_1234);
        step();
        chk("b_mask7_clr", {31'd0, pending_mask[7]}, 32'd0);

        // Starvation: queue x3, x4 under continuous A traffic
        a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hA0A0_0001;
        for (int k = 0; k < 12; k++) begin
            b_valid = (k < 2);
            b_rd    = (k == 0) ? 5'd3 : 5'd4;
            b_data  = 32'h0000_0300 + k;
            #1;
            if (k == 5) begin
                chk("starve_x3", {27'd0, w_regs_addr}, 32'd3);
                chk("starve_a_hold", {31'd0, a_ready}, 32'd0);
            end else if (k == 10) begin
                chk("starve_x4", {27'd0, w_regs_addr}, 32'd4);
                chk("starve_a_hold2", {31'd0, a_ready}, 32'd0);
            end else begin
                chk("starve_a", {27'd0, w_regs_addr}, 32'd1);
                chk("starve_a_ready", {31'd0, a_ready}, 32'd1);
            end
            step();
        end

        // Full + same-cycle pop
        b_valid = 1'b1; b_rd = 5'd10; b_data = 32'h0000_000A;
        step();
        b_rd = 5'd11; b_data = 32'h0000_000B;
        step();
        a_valid = 1'b0; b_rd = 5'd9; b_data = 32'h0000_0009;
        #1;
        chk("full_b_ready", {31'd0, b_ready}, 32'd0);
        chk("full_count", {30'd0, fifo_count}, 32'd2);
        chk("full_head", {27'd0, w_regs_addr}, 32'd10);
        step();
        chk("pop_b_ready", {31'd0, b_ready}, 32'd1);
        chk("pop_count", {30'd0, fifo_count}, 32'd1);
        chk("pop_head", {27'd0, w_regs_addr}, 32'd11);
        step();
        b_valid = 1'b0;
        #1;
        chk("pushpop_count", {30'd0, fifo_count}, 32'd1);
        chk("pushpop_head", {27'd0, w_regs_addr}, 32'd9);
        step();
        chk("drain_count", {30'd0, fifo_count}, 32'd0);

        // rd=0 on both sources
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h1111_1111;
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h2222_2222;
        #1;
        chk("x0_a_en", {31'd0, w_regs_en}, 32'd0);
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        chk("x0_b_en", {31'd0, w_regs_en}, 32'd0);
        chk("x0_count", {30'd0, fifo_count}, 32'd1);
        chk("x0_mask", pending_mask, 32'd0);
        step();
        chk("x0_drained", {30'd0, fifo_count}, 32'd0);

        // Two queued entries with the same rd
        a_valid = 1'b1; a_rd = 5'd2; a_data = 32'h0000_0002;
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h0000_0071;
        step();
        b_data = 32'h0000_0072;
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        chk("dup_mask_hold", pending_mask, 32'h0000_0080);
        step();
        chk("dup_mask_clr", pending_mask, 32'd0);

        // Reset mid-stream with two queued entries
        a_valid = 1'b1; a_rd = 5'd2;
        b_valid = 1'b1; b_rd = 5'd12; b_data = 32'h0000_00C0;
        step();
        b_rd = 5'd13; b_data = 32'h0000_00D0;
        step();
        b_valid = 1'b0;
        #1;
        chk("pre_rst_count", {30'd0, fifo_count}, 32'd2);
        chk("pre_rst_mask", pending_mask, 32'h0000_3000);
        a_valid = 1'b0; rst = 1'b1;
        #1;
        chk("async_count", {30'd0, fifo_count}, 32'd0);
        chk("async_mask", pending_mask, 32'd0);
        chk("async_en", {31'd0, w_regs_en}, 32'd0);
        chk("async_b_ready", {31'd0, b_ready}, 32'd1);
        step();
        rst = 1'b0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
